// File: rtl/mux_stream_rr.sv
// CH-way valid/ready stream mux with a single registered output stage; external select (MODE 0)
// or round-robin arbitration (MODE 1). Define MUX_STREAM_STATS_EN to add saturating per-channel grant counters.
module mux_stream_rr #(
    parameter int DW   = 4,
    parameter int CH   = 4,
    parameter int MODE = 0,
    parameter int CHW  = $clog2(CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*DW-1:0] in_data,
    input  logic [CH-1:0]    in_valid,
    output logic [CH-1:0]    in_ready,
    input  logic [CHW-1:0]   sel,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHW-1:0]   out_ch
`ifdef MUX_STREAM_STATS_EN
    ,
    output logic [CH*16-1:0] grant_cnt
`endif
);

    logic           vld_p1;
    logic [DW-1:0]  data_p1;
    logic [CHW-1:0] ch_p1;
    logic [CHW-1:0] ptr;
    logic [CHW-1:0] grant;
    logic           grant_vld;
    logic           load_en;
    logic [DW-1:0]  grant_data;
    logic [CHW-1:0] ptr_next;

    // The output register can take a new word when empty or when it is being drained this cycle.
    assign load_en = ~vld_p1 | out_ready;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        if (MODE == 0) begin
            // Out-of-range select values match no channel and therefore never grant.
            for (int i = 0; i < CH; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    grant     = CHW'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                for (int i = 0; i < CH; i++) begin
                    if (!grant_vld && in_valid[i] && ((int'(ptr) + k) % CH) == i) begin
                        grant     = CHW'(i);
                        grant_vld = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant == CHW'(i)) begin
                in_ready[i] = load_en & grant_vld;
                grant_data  = in_data[i*DW +: DW];
            end
        end
    end

    assign ptr_next = (grant == CHW'(CH - 1)) ? '0 : grant + 1'b1;

    // Stage p1: registered output word and arbitration pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            ptr     <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                vld_p1  <= 1'b1;
                data_p1 <= grant_data;
                ch_p1   <= grant;
                ptr     <= ptr_next;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;

`ifdef MUX_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (in_ready[i] && in_valid[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr: directed scenarios plus randomized traffic against a behavioural model,
// using a select-mode, a round-robin and a 3-channel select-mode instance.
module tb_mux_stream_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] d0, d1;
    logic [3:0]  v0, v1, r0, r1, od0, od1;
    logic [1:0]  s0, s1, oc0, oc1;
    logic        ov0, ov1, ordy0, ordy1;
    logic [11:0] d3;
    logic [2:0]  v3, r3;
    logic [1:0]  s3, oc3;
    logic [3:0]  od3;
    logic        ov3, ordy3;
`ifdef MUX_STREAM_STATS_EN
    logic [63:0] gc0, gc1;
    logic [47:0] gc3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mux_stream_rr #(.DW(4), .CH(4), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
        .out_data(od0), .out_valid(ov0), .out_ready(ordy0), .out_ch(oc0)
`ifdef MUX_STREAM_STATS_EN
        , .grant_cnt(gc0)
`endif
    );

    mux_stream_rr #(.DW(4), .CH(4), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
        .out_data(od1), .out_valid(ov1), .out_ready(ordy1), .out_ch(oc1)
`ifdef MUX_STREAM_STATS_EN
        , .grant_cnt(gc1)
`endif
    );

    mux_stream_rr #(.DW(4), .CH(3), .MODE(0)) u_m3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3), .sel(s3),
        .out_data(od3), .out_valid(ov3), .out_ready(ordy3), .out_ch(oc3)
`ifdef MUX_STREAM_STATS_EN
        , .grant_cnt(gc3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d0 = '0; v0 = '0; s0 = '0; ordy0 = 1'b0;
        d1 = '0; v1 = '0; s1 = '0; ordy1 = 1'b0;
        d3 = '0; v3 = '0; s3 = '0; ordy3 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // Reference grant: select mode takes sel if that channel is valid; round-robin takes the
    // first valid channel found scanning upward from the pointer with wrap.
    function automatic int model_grant(int mode, logic [3:0] v, int s, int p);
        logic [3:0] m;
        if (mode == 0) begin
            m = 4'b0001 << s;
            return (s < 4 && (v & m) != 4'b0) ? s : -1;
        end
        for (int k = 0; k < 4; k++) begin
            m = 4'b0001 << ((p + k) % 4);
            if ((v & m) != 4'b0) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL reset_ov0: got %b want 0", ov0); end
        n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_ov1: got %b want 0", ov1); end
        n_cmp++; if (od0 !== 4'h0 || oc0 !== 2'd0) begin n_err++; $display("FAIL reset_data0: got %h/%0d want 0/0", od0, oc0); end
        n_cmp++; if (r0 !== 4'b0 || r1 !== 4'b0 || r3 !== 3'b0) begin n_err++; $display("FAIL reset_ready: got %b %b %b want 0", r0, r1, r3); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mode0();
        s0 = 2'd2; v0 = 4'b0110; d0 = {4'h0, 4'hA, 4'h5, 4'h0}; ordy0 = 1'b1;
        @(negedge clk);
        n_cmp++; if (r0 !== 4'b0100) begin n_err++; $display("FAIL m0_ready_sel2: got %b want 0100", r0); end
        tick();
        n_cmp++; if (ov0 !== 1'b1 || od0 !== 4'hA || oc0 !== 2'd2) begin n_err++; $display("FAIL m0_out_sel2: got v%b %h ch%0d want v1 a ch2", ov0, od0, oc0); end
        s0 = 2'd3;
        @(negedge clk);
        n_cmp++; if (r0 !== 4'b0000) begin n_err++; $display("FAIL m0_ready_sel3: got %b want 0000", r0); end
        tick();
        n_cmp++; if (ov0 !== 1'b0 || od0 !== 4'hA || oc0 !== 2'd2) begin n_err++; $display("FAIL m0_nogrant: got v%b %h ch%0d want v0 a ch2", ov0, od0, oc0); end
    endtask

    task automatic test_sel_oob();
        v3 = 3'b111; d3 = {4'h3, 4'h2, 4'h1}; ordy3 = 1'b1; s3 = 2'd3;
        @(negedge clk);
        n_cmp++; if (r3 !== 3'b000) begin n_err++; $display("FAIL oob_ready: got %b want 000", r3); end
        tick();
        n_cmp++; if (ov3 !== 1'b0) begin n_err++; $display("FAIL oob_valid: got %b want 0", ov3); end
        s3 = 2'd2;
        @(negedge clk);
        n_cmp++; if (r3 !== 3'b100) begin n_err++; $display("FAIL ch3_ready_sel2: got %b want 100", r3); end
        tick();
        n_cmp++; if (ov3 !== 1'b1 || od3 !== 4'h3 || oc3 !== 2'd2) begin n_err++; $display("FAIL ch3_out: got v%b %h ch%0d want v1 3 ch2", ov3, od3, oc3); end
    endtask

    task automatic test_sel_stall();
        s0 = 2'd1; v0 = 4'b0110; d0 = {4'h0, 4'hA, 4'h5, 4'h0}; ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0; s0 = 2'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (r0 !== 4'b0 || ov0 !== 1'b1 || od0 !== 4'h5 || oc0 !== 2'd1) begin
                n_err++; $display("FAIL stall_m0 c%0d: got r%b v%b %h ch%0d want r0000 v1 5 ch1", c, r0, ov0, od0, oc0);
            end
            tick();
        end
        ordy0 = 1'b1;
        @(negedge clk);
        n_cmp++; if (r0 !== 4'b0100) begin n_err++; $display("FAIL stall_m0_release_ready: got %b want 0100", r0); end
        tick();
        n_cmp++; if (ov0 !== 1'b1 || od0 !== 4'hA || oc0 !== 2'd2) begin n_err++; $display("FAIL stall_m0_b2b: got v%b %h ch%0d want v1 a ch2", ov0, od0, oc0); end
    endtask

    task automatic test_rr_fair();
        int exp_ch [6];
        exp_ch = '{0, 1, 2, 3, 0, 1};
        do_reset();
        v1 = 4'hF; d1 = {4'h3, 4'h2, 4'h1, 4'h0}; ordy1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++; if (ov1 !== 1'b1 || oc1 !== 2'(exp_ch[k]) || od1 !== 4'(exp_ch[k])) begin
                n_err++; $display("FAIL rr_fair k%0d: got v%b ch%0d d%h want v1 ch%0d", k, ov1, oc1, od1, exp_ch[k]);
            end
        end
    endtask

    task automatic test_rr_wrap();
        logic [3:0] exp_r [3];
        int         exp_c [3];
        exp_r = '{4'b0001, 4'b0010, 4'b0001};
        exp_c = '{0, 1, 0};
        do_reset();
        v1 = 4'b0100; d1 = {4'h3, 4'h2, 4'h1, 4'h0}; ordy1 = 1'b1;
        tick();
        v1 = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (r1 !== exp_r[k]) begin n_err++; $display("FAIL rr_wrap_ready k%0d: got %b want %b", k, r1, exp_r[k]); end
            tick();
            n_cmp++; if (oc1 !== 2'(exp_c[k])) begin n_err++; $display("FAIL rr_wrap_ch k%0d: got %0d want %0d", k, oc1, exp_c[k]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        v1 = 4'hF; d1 = {4'h3, 4'h2, 4'h1, 4'h0}; ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (r1 !== 4'b0 || ov1 !== 1'b1 || od1 !== 4'h0 || oc1 !== 2'd0) begin
                n_err++; $display("FAIL bp_stall c%0d: got r%b v%b %h ch%0d want r0000 v1 0 ch0", c, r1, ov1, od1, oc1);
            end
            tick();
        end
        ordy1 = 1'b1;
        @(negedge clk);
        n_cmp++; if (r1 !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", r1); end
        tick();
        n_cmp++; if (ov1 !== 1'b1 || oc1 !== 2'd1 || od1 !== 4'h1) begin n_err++; $display("FAIL bp_b2b: got v%b ch%0d d%h want v1 ch1 d1", ov1, oc1, od1); end
    endtask

    task automatic test_reset_mid();
        ordy1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (ov1 !== 1'b0 || od1 !== 4'h0 || oc1 !== 2'd0) begin
            n_err++; $display("FAIL midreset_async: got v%b %h ch%0d want v0 0 ch0", ov1, od1, oc1);
        end
        @(negedge clk);
        rst = 1'b1; v1 = 4'b1010; ordy1 = 1'b1;
        #1;
        n_cmp++; if (r1 !== 4'b0010) begin n_err++; $display("FAIL midreset_ptr_ready: got %b want 0010", r1); end
        tick();
        n_cmp++; if (ov1 !== 1'b1 || oc1 !== 2'd1) begin n_err++; $display("FAIL midreset_first_grant: got v%b ch%0d want v1 ch1", ov1, oc1); end
    endtask

    task automatic test_random();
        bit         pv [2][4];
        logic [3:0] pd [2][4];
        bit         mv [2];
        logic [3:0] md [2];
        int         mc [2];
        int         mp [2];
        int         g, ss;
        bit         le, ordy, ov;
        logic [3:0] vv, rdy, er, od;
        logic [1:0] oc;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; md[m] = 4'h0; mc[m] = 0; mp[m] = 0;
            for (int c = 0; c < 4; c++) begin pv[m][c] = 1'b0; pd[m][c] = 4'h0; end
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < 2; m++)
                for (int c = 0; c < 4; c++)
                    if (!pv[m][c] && $urandom_range(0, 2) != 0) begin
                        pv[m][c] = 1'b1;
                        pd[m][c] = 4'($urandom);
                    end
            for (int c = 0; c < 4; c++) begin
                v0[c] = pv[0][c]; d0[c*4 +: 4] = pd[0][c];
                v1[c] = pv[1][c]; d1[c*4 +: 4] = pd[1][c];
            end
            s0 = 2'($urandom); s1 = 2'($urandom);
            ordy0 = ($urandom_range(0, 3) != 0);
            ordy1 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                vv   = (m == 0) ? v0 : v1;
                ss   = (m == 0) ? int'(s0) : int'(s1);
                ordy = (m == 0) ? ordy0 : ordy1;
                rdy  = (m == 0) ? r0 : r1;
                ov   = (m == 0) ? ov0 : ov1;
                od   = (m == 0) ? od0 : od1;
                oc   = (m == 0) ? oc0 : oc1;
                g  = model_grant(m, vv, ss, mp[m]);
                le = !mv[m] || ordy;
                er = (le && g >= 0) ? (4'b0001 << g) : 4'b0000;
                n_cmp++; if (rdy !== er) begin n_err++; $display("FAIL rnd_ready m%0d cyc%0d: got %b want %b", m, cyc, rdy, er); end
                n_cmp++; if (ov !== mv[m]) begin n_err++; $display("FAIL rnd_valid m%0d cyc%0d: got %b want %b", m, cyc, ov, mv[m]); end
                n_cmp++; if (od !== md[m] || oc !== 2'(mc[m])) begin
                    n_err++; $display("FAIL rnd_word m%0d cyc%0d: got %h ch%0d want %h ch%0d", m, cyc, od, oc, md[m], mc[m]);
                end
                if (le) begin
                    if (g >= 0) begin
                        mv[m] = 1'b1; md[m] = pd[m][g]; mc[m] = g; mp[m] = (g + 1) % 4;
                        pv[m][g] = 1'b0;
                    end else begin
                        mv[m] = 1'b0;
                    end
                end
            end
            tick();
        end
    endtask

`ifdef MUX_STREAM_STATS_EN
    task automatic test_stats();
        do_reset();
        s0 = 2'd1; v0 = 4'b0010; d0 = {4'h0, 4'h0, 4'h7, 4'h0}; ordy0 = 1'b1;
        repeat (100) tick();
        n_cmp++; if (gc0[31:16] !== 16'd100) begin n_err++; $display("FAIL stats_count100: got %0d want 100", gc0[31:16]); end
        repeat (65440) tick();
        n_cmp++; if (gc0[31:16] !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat: got %h want ffff", gc0[31:16]); end
        n_cmp++; if (gc0[15:0] !== 16'h0 || gc0[63:32] !== 32'h0) begin n_err++; $display("FAIL stats_others: got %h want 0 elsewhere", gc0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (gc0 !== 64'h0 || gc1 !== 64'h0) begin n_err++; $display("FAIL stats_reset: got %h %h want 0", gc0, gc1); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask
`endif

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_sel_oob();
        test_sel_stall();
        test_rr_fair();
        test_rr_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef MUX_STREAM_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
